// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers and the PC. Produces per-stage write enables and bubble
//   (flush) strobes from load-use hazards, taken branches resolved in
//   EX/MEM, and a variable-latency data-memory handshake guarded by a
//   timeout watchdog.
//
//   Priority of conditions: freeze > taken branch > load-use > normal.
//
// Parameters
//   MEM_TIMEOUT  max consecutive dmem-wait count before TIMEOUT (1..255)
//   CNT_W        performance counter width (PIPE_PERF_CNT_EN only)
//
// Ports
//   clk, reset                  clock; synchronous active-low reset
//   if_id_rs1/rs2/uses_rs2      source registers of the IF/ID instruction
//   id_ex_memRead, id_ex_rd     load in ID/EX and its destination
//   ex_mem_branch/alu_zero      branch in EX/MEM and its outcome
//   ex_mem_memRead/memWrite     memory access in EX/MEM
//   dmem_ready                  data memory completes this cycle
//   pc_write, pc_sel_branch     PC enable / select branch target
//   *_write, *_flush            per-stage enables and bubble strobes
//   dmem_timeout                sticky watchdog flag
//
// Configuration macro
//   PIPE_PERF_CNT_EN  adds stall_cnt / flush_cnt / freeze_cnt outputs

module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic             id_ex_memRead,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_mem_branch,
  input  logic             ex_mem_alu_zero,
  input  logic             ex_mem_memRead,
  input  logic             ex_mem_memWrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic             mem_wb_write,
  output logic             dmem_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
    $error("pipeline_hazard_ctrl: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       timeout_next;

  logic mem_acc;
  logic freeze;
  logic take;
  logic lu;

  // Hazard terms. Each lower-priority term is masked by the higher ones,
  // so at most one of freeze/take/lu is active in any cycle.
  always_comb begin
    mem_acc = ex_mem_memRead | ex_mem_memWrite;
    freeze  = (state == TIMEOUT) | (mem_acc & ~dmem_ready);
    take    = ex_mem_branch & ex_mem_alu_zero & ~freeze;
    lu      = id_ex_memRead & (id_ex_rd != 5'd0)
              & ((id_ex_rd == if_id_rs1) | (if_id_uses_rs2 & (id_ex_rd == if_id_rs2)))
              & ~freeze & ~take;
  end

  // Control outputs: all zero while reset is asserted or the pipe is frozen.
  always_comb begin
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_write  = 1'b0;
    if (reset && !freeze) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      if (take) begin
        pc_sel_branch = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_flush  = 1'b1;
      end else if (lu) begin
        // Hold PC and IF/ID, inject a bubble into ID/EX.
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Memory-wait sequencer and watchdog.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_next  = dmem_timeout;
    unique case (state)
      RUN: begin
        if (mem_acc && !dmem_ready) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          state_next    = TIMEOUT;
          timeout_next  = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      TIMEOUT: begin
        state_next = TIMEOUT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      dmem_timeout <= 1'b0;
    end else begin
      state        <= state_next;
      wait_cnt     <= wait_cnt_next;
      dmem_timeout <= timeout_next;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (lu)     stall_cnt  <= stall_cnt + CNT_ONE;
      if (take)   flush_cnt  <= flush_cnt + CNT_ONE;
      if (freeze) freeze_cnt <= freeze_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT = 4.
//   Inputs change just after the falling edge; the combinational outputs
//   are sampled 1 time unit later, well away from the rising edge.
//   Observed vector: {pc_write, pc_sel_branch, if_id_write, if_id_flush,
//   id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_write,
//   dmem_timeout}.

module tb_pipeline_hazard_ctrl;

  localparam logic [9:0] P_ZERO   = 10'b0000000000;
  localparam logic [9:0] P_NORMAL = 10'b1010101010;
  localparam logic [9:0] P_TAKE   = 10'b1111111110;
  localparam logic [9:0] P_LU     = 10'b0000111010;
  localparam logic [9:0] P_FREEZE = 10'b0000000000;
  localparam logic [9:0] P_TO     = 10'b0000000001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       if_id_uses_rs2, id_ex_memRead;
  logic       ex_mem_branch, ex_mem_alu_zero, ex_mem_memRead, ex_mem_memWrite;
  logic       dmem_ready;
  logic       pc_write, pc_sel_branch, if_id_write, if_id_flush;
  logic       id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush;
  logic       mem_wb_write, dmem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .if_id_uses_rs2  (if_id_uses_rs2),
    .id_ex_memRead   (id_ex_memRead),
    .id_ex_rd        (id_ex_rd),
    .ex_mem_branch   (ex_mem_branch),
    .ex_mem_alu_zero (ex_mem_alu_zero),
    .ex_mem_memRead  (ex_mem_memRead),
    .ex_mem_memWrite (ex_mem_memWrite),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .pc_sel_branch   (pc_sel_branch),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_flush    (ex_mem_flush),
    .mem_wb_write    (mem_wb_write),
    .dmem_timeout    (dmem_timeout)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .freeze_cnt      (freeze_cnt)
`endif
  );

  function automatic logic [9:0] obs();
    return {pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write,
            id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_write, dmem_timeout};
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    if_id_rs1 = '0; if_id_rs2 = '0; if_id_uses_rs2 = 1'b0;
    id_ex_memRead = 1'b0; id_ex_rd = '0;
    ex_mem_branch = 1'b0; ex_mem_alu_zero = 1'b0;
    ex_mem_memRead = 1'b0; ex_mem_memWrite = 1'b0;
    dmem_ready = 1'b1;
  endtask

  task automatic set_lu();
    id_ex_memRead = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic sample(input string tag, input logic [9:0] exp);
    #1;
    check(tag, obs(), exp);
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    set_lu();
    next_cycle(); sample("rst_out_a", P_ZERO);
    next_cycle(); sample("rst_out_b", P_ZERO);

    next_cycle(); reset = 1'b1; clear_inputs();
    sample("after_rst", P_NORMAL);

    // Load-use detection.
    next_cycle(); set_lu(); sample("lu_rs1", P_LU);
    next_cycle(); clear_inputs(); sample("lu_1cyc", P_NORMAL);
    next_cycle(); id_ex_memRead = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5;
    if_id_uses_rs2 = 1'b1; sample("lu_rs2", P_LU);
    next_cycle(); if_id_uses_rs2 = 1'b0; sample("lu_rs2_unused", P_NORMAL);
    next_cycle(); clear_inputs(); id_ex_memRead = 1'b1; id_ex_rd = 5'd0;
    if_id_rs1 = 5'd0; sample("lu_rd0", P_NORMAL);
    next_cycle(); clear_inputs(); if_id_rs1 = 5'd5; id_ex_rd = 5'd5;
    sample("no_load", P_NORMAL);

    // Branch beats load-use; untaken branch leaves load-use in effect.
    next_cycle(); clear_inputs(); set_lu(); ex_mem_branch = 1'b1; ex_mem_alu_zero = 1'b1;
    sample("take_over_lu", P_TAKE);
    next_cycle(); ex_mem_alu_zero = 1'b0; sample("untaken_lu", P_LU);

    // Memory wait of 3 cycles with taken branch and load-use pending.
    next_cycle(); ex_mem_alu_zero = 1'b1; ex_mem_memRead = 1'b1; dmem_ready = 1'b0;
    sample("wait_c0", P_FREEZE);
    next_cycle(); sample("wait_c1", P_FREEZE);
    next_cycle(); sample("wait_c2", P_FREEZE);
    next_cycle(); dmem_ready = 1'b1; sample("release_take", P_TAKE);
    next_cycle(); clear_inputs(); sample("run_after_rel", P_NORMAL);

    // Zero-latency store, then a wait released on the last allowed cycle.
    next_cycle(); ex_mem_memWrite = 1'b1; sample("zero_lat", P_NORMAL);
    next_cycle(); ex_mem_memWrite = 1'b0; ex_mem_memRead = 1'b1; dmem_ready = 1'b0;
    sample("w4_c0", P_FREEZE);
    next_cycle(); sample("w4_c1", P_FREEZE);
    next_cycle(); sample("w4_c2", P_FREEZE);
    next_cycle(); sample("w4_c3", P_FREEZE);
    next_cycle(); dmem_ready = 1'b1; sample("w4_c4_release", P_NORMAL);
    next_cycle(); clear_inputs(); sample("w4_after", P_NORMAL);

    // Timeout: five wait cycles, then the absorbing TIMEOUT state.
    next_cycle(); ex_mem_memRead = 1'b1; dmem_ready = 1'b0; sample("to_c0", P_FREEZE);
    repeat (3) begin next_cycle(); end
    sample("to_c3", P_FREEZE);
    next_cycle(); sample("to_c4", P_FREEZE);
    next_cycle(); sample("to_c5", P_TO);
    next_cycle(); clear_inputs(); ex_mem_branch = 1'b1; ex_mem_alu_zero = 1'b1;
    sample("to_absorb", P_TO);
    next_cycle(); sample("to_absorb2", P_TO);

    // Reset clears the watchdog.
    next_cycle(); reset = 1'b0; sample("rst_in_to", P_TO);
    next_cycle(); sample("rst_to_cleared", P_ZERO);
    next_cycle(); reset = 1'b1; clear_inputs(); sample("run_after_to", P_NORMAL);

    // Reset in the middle of MEM_WAIT restarts the wait count.
    next_cycle(); ex_mem_memRead = 1'b1; dmem_ready = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
    reset = 1'b0; sample("rst_in_wait", P_ZERO);
    next_cycle(); reset = 1'b1; sample("rw_c0", P_FREEZE);
    repeat (3) begin next_cycle(); end
    sample("rw_c3", P_FREEZE);
    next_cycle(); sample("rw_c4", P_FREEZE);
    next_cycle(); sample("rw_c5", P_TO);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
